// File: rtl/mul_job_sequencer.sv
// Job sequencer around the 8-bit shift-add multiplier core: accepts operand pairs, times the
// core's fixed latency, and buffers one product behind a valid/ready output handshake.
module mul_job_sequencer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned INIT_CYCLES = 1,
    parameter int unsigned LATENCY     = 18,
    parameter int unsigned COUNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     mul_multiplicand,
    output logic [WIDTH-1:0]     mul_multiplier,
    output logic                 mul_init,
    input  logic [2*WIDTH-1:0]   mul_produto,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy,
    output logic [COUNT_W-1:0]   op_count
);

    localparam int unsigned CntMax = (INIT_CYCLES > LATENCY) ? INIT_CYCLES : LATENCY;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StOut} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            count_q <= count_d;
        end
    end

    // Completion is purely cycle-counted; the core has no done flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = CntW'(INIT_CYCLES - 1);
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(LATENCY - 1);
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    prod_d  = mul_produto;
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    count_d = count_q + COUNT_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode registered state only, so async reset clears mul_init immediately.
    always_comb begin
        in_ready         = (state_q == StIdle);
        mul_init         = (state_q == StStart);
        out_valid        = (state_q == StOut);
        busy             = (state_q != StIdle);
        mul_multiplicand = a_q;
        mul_multiplier   = b_q;
        out_product      = prod_q;
        op_count         = count_q;
    end

endmodule

// File: tb/tb_mul_job_sequencer.sv
// Directed bench for mul_job_sequencer with a cycle-timed behavioural multiplier core model.
module tb_mul_job_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [7:0]  mul_multiplicand;
    logic [7:0]  mul_multiplier;
    logic        mul_init;
    logic [15:0] mul_produto;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        busy;
    logic [7:0]  op_count;

    int n_cmp  = 0;
    int n_fail = 0;

    mul_job_sequencer #(
        .WIDTH(8), .INIT_CYCLES(1), .LATENCY(18), .COUNT_W(8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_init         (mul_init),
        .mul_produto      (mul_produto),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .busy             (busy),
        .op_count         (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core model: product is garbage until 17 cycles have elapsed after init falls.
    logic [7:0] mc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             mc <= 8'd0;
        else if (mul_init)      mc <= 8'd0;
        else if (mc != 8'hFF)   mc <= mc + 8'd1;
    end
    assign mul_produto = (!mul_init && mc >= 8'd17) ?
                         16'(mul_multiplicand) * 16'(mul_multiplier) : 16'h5A5A;

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Offers one job from IDLE, returns cycles from accept to out_valid and init-high cycles.
    task automatic do_job(input logic [7:0] a, input logic [7:0] b, input bit ack,
                          output int lat, output int inits, output logic [15:0] prod);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; inits = 0;
        while (!out_valid && lat < 100) begin
            inits += int'(mul_init);
            @(posedge clk); #1;
            lat++;
        end
        prod = out_product;
        if (ack) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        #12;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (mul_init !== 1'b0) begin n_fail++; $display("FAIL rst_mul_init: got %b want 0", mul_init); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL rst_op_count: got %0d want 0", op_count); end
        n_cmp++; if (out_product !== 16'h0) begin n_fail++; $display("FAIL rst_out_product: got %h want 0000", out_product); end
        n_cmp++; if ({mul_multiplicand, mul_multiplier} !== 16'h0) begin n_fail++;
            $display("FAIL rst_operands: got %h want 0000", {mul_multiplicand, mul_multiplier}); end
        apply_reset();
    endtask

    task automatic test_basic();
        int lat, inits; logic [15:0] prod;
        do_job(8'd13, 8'd11, 1'b1, lat, inits, prod);
        n_cmp++; if (lat !== 19) begin n_fail++; $display("FAIL basic_latency: got %0d want 19", lat); end
        n_cmp++; if (inits !== 1) begin n_fail++; $display("FAIL basic_init_cycles: got %0d want 1", inits); end
        n_cmp++; if (prod !== 16'h008F) begin n_fail++; $display("FAIL basic_product: got %h want 008f", prod); end
        n_cmp++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL basic_op_count: got %0d want 1", op_count); end
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL basic_idle_after: got ready=%b busy=%b want 1 0", in_ready, busy); end
        n_cmp++; if (mul_multiplicand !== 8'd13 || mul_multiplier !== 8'd11) begin n_fail++;
            $display("FAIL basic_operands_held: got %0d %0d want 13 11", mul_multiplicand, mul_multiplier); end
    endtask

    task automatic test_max();
        int lat, inits; logic [15:0] prod;
        do_job(8'd255, 8'd255, 1'b1, lat, inits, prod);
        n_cmp++; if (prod !== 16'hFE01) begin n_fail++; $display("FAIL max_product: got %h want fe01", prod); end
        n_cmp++; if (lat !== 19) begin n_fail++; $display("FAIL max_latency: got %0d want 19", lat); end
        do_job(8'd0, 8'd200, 1'b1, lat, inits, prod);
        n_cmp++; if (prod !== 16'h0000) begin n_fail++; $display("FAIL zero_product: got %h want 0000", prod); end
        n_cmp++; if (op_count !== 8'd3) begin n_fail++; $display("FAIL max_op_count: got %0d want 3", op_count); end
    endtask

    task automatic test_backpressure();
        int lat, inits; logic [15:0] prod;
        do_job(8'd7, 8'd9, 1'b0, lat, inits, prod);
        n_cmp++; if (prod !== 16'h003F) begin n_fail++; $display("FAIL bp_product: got %h want 003f", prod); end
        in_a = 8'd99; in_b = 8'd77; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++;
                $display("FAIL bp_hold_flags: cycle %0d got valid=%b ready=%b want 1 0", i, out_valid, in_ready); end
            n_cmp++; if (out_product !== 16'h003F) begin n_fail++;
                $display("FAIL bp_hold_product: cycle %0d got %h want 003f", i, out_product); end
            n_cmp++; if (mul_multiplicand !== 8'd7 || mul_multiplier !== 8'd9) begin n_fail++;
                $display("FAIL bp_hold_operands: cycle %0d got %0d %0d want 7 9", i, mul_multiplicand, mul_multiplier); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (op_count !== 8'd4) begin n_fail++; $display("FAIL bp_op_count: got %0d want 4", op_count); end
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ja [4];
        logic [7:0]  jb [4];
        logic [15:0] exp_p [4];
        int idx, res, cyc, ready_cnt;
        bit acc;
        ja = '{8'd1, 8'd2, 8'd16, 8'd128};
        jb = '{8'd1, 8'd3, 8'd16, 8'd2};
        exp_p = '{16'd1, 16'd6, 16'd256, 16'd256};
        apply_reset();
        idx = 0; res = 0; cyc = 0; ready_cnt = 0;
        in_a = ja[0]; in_b = jb[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (res < 4 && cyc < 200) begin
            if (in_ready) ready_cnt++;
            if (out_valid) begin
                n_cmp++; if (out_product !== exp_p[res]) begin n_fail++;
                    $display("FAIL b2b_product: job %0d got %0d want %0d", res, out_product, exp_p[res]); end
                res++;
            end
            acc = in_ready && in_valid;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) begin in_a = ja[idx]; in_b = jb[idx]; end
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0; in_valid = 1'b0;
        n_cmp++; if (res !== 4) begin n_fail++; $display("FAIL b2b_results: got %0d want 4", res); end
        n_cmp++; if (cyc !== 84) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 84", cyc); end
        n_cmp++; if (ready_cnt !== 4) begin n_fail++; $display("FAIL b2b_ready_cycles: got %0d want 4", ready_cnt); end
        n_cmp++; if (op_count !== 8'd4) begin n_fail++; $display("FAIL b2b_op_count: got %0d want 4", op_count); end
    endtask

    task automatic test_reset_mid_wait();
        int lat, inits; logic [15:0] prod;
        // Reset during START: mul_init must fall without a clock edge.
        in_a = 8'd5; in_b = 8'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (mul_init !== 1'b1) begin n_fail++; $display("FAIL start_init: got %b want 1", mul_init); end
        rst_n = 1'b0; #1;
        n_cmp++; if (mul_init !== 1'b0) begin n_fail++; $display("FAIL start_rst_init: got %b want 0", mul_init); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_job(8'd2, 8'd2, 1'b1, lat, inits, prod);
        in_a = 8'd21; in_b = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
            $display("FAIL wait_state: got busy=%b valid=%b want 1 0", busy, out_valid); end
        rst_n = 1'b0; #1;
        n_cmp++; if (mul_init !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL wait_rst_flags: got init=%b valid=%b busy=%b ready=%b want 0 0 0 1",
                     mul_init, out_valid, busy, in_ready); end
        n_cmp++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL wait_rst_op_count: got %0d want 0", op_count); end
        n_cmp++; if (out_product !== 16'h0 || mul_multiplicand !== 8'd0) begin n_fail++;
            $display("FAIL wait_rst_data: got %h %0d want 0000 0", out_product, mul_multiplicand); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_job(8'd3, 8'd5, 1'b1, lat, inits, prod);
        n_cmp++; if (prod !== 16'd15 || lat !== 19) begin n_fail++;
            $display("FAIL post_rst_job: got prod=%0d lat=%0d want 15 19", prod, lat); end
        n_cmp++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL post_rst_op_count: got %0d want 1", op_count); end
    endtask

    task automatic test_wrap();
        int lat, inits; logic [15:0] prod; logic [7:0] a, b;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            b = 8'(i * 3 + 1);
            do_job(a, b, 1'b1, lat, inits, prod);
            n_cmp++; if (prod !== 16'(a) * 16'(b)) begin n_fail++;
                $display("FAIL wrap_product: job %0d got %0d want %0d", i, prod, 16'(a) * 16'(b)); end
            if (i == 254) begin
                n_cmp++; if (op_count !== 8'd255) begin n_fail++;
                    $display("FAIL wrap_pre: got %0d want 255", op_count); end
            end
        end
        n_cmp++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL wrap_post: got %0d want 0", op_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
